// File: rtl/pll_reset_sequencer.sv
// Reset and lock supervisor for the clock-generation PLL: sequences pll_rst,
// supervises the synchronized lock indicator and holds sys_rst until lock is stable.
module pll_reset_sequencer #(
  parameter int LOCK_SYNC_STAGES = 2,
  parameter int PLL_RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT     = 100000,
  parameter int STABLE_CYCLES    = 1024
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       lock_lost,
  output logic [7:0] retries
);

  localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CYC = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  // Each timed state spends exactly N edges after entry; cnt is 0 on entry.
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  localparam logic [1:0] S_RESET_PLL = 2'd0;
  localparam logic [1:0] S_WAIT_LOCK = 2'd1;
  localparam logic [1:0] S_STABLE    = 2'd2;
  localparam logic [1:0] S_RUN       = 2'd3;

  logic [LOCK_SYNC_STAGES-1:0] sync_reg;
  logic                        locked_s;

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             timeout_hit, loss_hit;

  logic       pll_rst_reg, sys_rst_reg, ready_reg, lock_lost_reg;
  logic [7:0] retries_reg;

  always_ff @(posedge refclk) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[LOCK_SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign locked_s = sync_reg[LOCK_SYNC_STAGES-1];

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg + CNT_W'(1);
    timeout_hit = 1'b0;
    loss_hit    = 1'b0;
    case (state_reg)
      S_RESET_PLL: begin
        if (cnt_reg == RST_LAST) begin
          state_next = S_WAIT_LOCK;
          cnt_next   = '0;
        end
      end
      S_WAIT_LOCK: begin
        // Lock is checked first so it beats a simultaneous timeout.
        if (locked_s) begin
          state_next = S_STABLE;
          cnt_next   = '0;
        end else if (cnt_reg == TO_LAST) begin
          state_next  = S_RESET_PLL;
          cnt_next    = '0;
          timeout_hit = 1'b1;
        end
      end
      S_STABLE: begin
        if (!locked_s) begin
          state_next = S_WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt_reg == STABLE_LAST) begin
          state_next = S_RUN;
          cnt_next   = '0;
        end
      end
      S_RUN: begin
        cnt_next = cnt_reg;
        if (!locked_s) begin
          state_next = S_RESET_PLL;
          cnt_next   = '0;
          loss_hit   = 1'b1;
        end
      end
      default: begin
        state_next = S_RESET_PLL;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_reg     <= S_RESET_PLL;
      cnt_reg       <= '0;
      pll_rst_reg   <= 1'b1;
      sys_rst_reg   <= 1'b1;
      ready_reg     <= 1'b0;
      lock_lost_reg <= 1'b0;
      retries_reg   <= 8'd0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      pll_rst_reg   <= (state_next == S_RESET_PLL);
      sys_rst_reg   <= (state_next != S_RUN);
      ready_reg     <= (state_next == S_RUN);
      lock_lost_reg <= loss_hit;
      if ((timeout_hit || loss_hit) && (retries_reg != 8'hFF)) begin
        retries_reg <= retries_reg + 8'd1;
      end
    end
  end

  assign pll_rst   = pll_rst_reg;
  assign sys_rst   = sys_rst_reg;
  assign ready     = ready_reg;
  assign lock_lost = lock_lost_reg;
  assign retries   = retries_reg;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with PLL_RST_CYCLES=4, LOCK_TIMEOUT=50,
// STABLE_CYCLES=8, LOCK_SYNC_STAGES=2; expected values are hand-derived edge counts.
module tb_pll_reset_sequencer;

  logic       refclk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       lock_lost;
  logic [7:0] retries;

  int checks = 0;
  int errors = 0;

  pll_reset_sequencer #(
    .LOCK_SYNC_STAGES(2),
    .PLL_RST_CYCLES  (4),
    .LOCK_TIMEOUT    (50),
    .STABLE_CYCLES   (8)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .pll_locked(pll_locked),
    .pll_rst   (pll_rst),
    .sys_rst   (sys_rst),
    .ready     (ready),
    .lock_lost (lock_lost),
    .retries   (retries)
  );

  always #5 refclk = ~refclk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drop lock while in RUN; outputs react on the second edge after the drop.
  task automatic lose_lock(input int exp_retries);
    pll_locked = 1'b0;
    tick();
    check("loss_e0_lock_lost", 32'(lock_lost), 32'd0);
    check("loss_e0_sys_rst", 32'(sys_rst), 32'd0);
    tick();
    check("loss_e1_lock_lost", 32'(lock_lost), 32'd0);
    tick();
    check("loss_e2_lock_lost", 32'(lock_lost), 32'd1);
    check("loss_e2_sys_rst", 32'(sys_rst), 32'd1);
    check("loss_e2_pll_rst", 32'(pll_rst), 32'd1);
    check("loss_e2_ready", 32'(ready), 32'd0);
    check("loss_e2_retries", 32'(retries), 32'(exp_retries));
    $display("lock loss: retries=%0d", retries);
  endtask

  initial begin
    // Power-up reset
    rst = 1'b1;
    pll_locked = 1'b0;
    tick_n(3);
    check("rst_pll_rst", 32'(pll_rst), 32'd1);
    check("rst_sys_rst", 32'(sys_rst), 32'd1);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_lock_lost", 32'(lock_lost), 32'd0);
    check("rst_retries", 32'(retries), 32'd0);
    $display("reset: pll_rst=%0b sys_rst=%0b retries=%0d", pll_rst, sys_rst, retries);

    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("pwr_pll_rst", 32'(pll_rst), (i < 4) ? 32'd1 : 32'd0);
      check("pwr_sys_rst", 32'(sys_rst), 32'd1);
      check("pwr_retries", 32'(retries), 32'd0);
    end
    $display("power-up: pll_rst released after 4 edges");

    // Two timeouts: 50 edges in WAIT_LOCK, then 4 edges of pll_rst
    for (int r = 1; r <= 2; r++) begin
      tick_n(49);
      check("to_pre_pll_rst", 32'(pll_rst), 32'd0);
      check("to_pre_retries", 32'(retries), 32'(r - 1));
      tick();
      check("to_pll_rst", 32'(pll_rst), 32'd1);
      check("to_retries", 32'(retries), 32'(r));
      check("to_lock_lost", 32'(lock_lost), 32'd0);
      for (int i = 1; i <= 4; i++) begin
        tick();
        check("to_hold_pll_rst", 32'(pll_rst), (i < 4) ? 32'd1 : 32'd0);
      end
      $display("timeout %0d: retries=%0d", r, retries);
    end

    // Lock arrives on the same edge the timeout would fire
    tick_n(47);
    pll_locked = 1'b1;
    tick_n(3);
    check("tie_pll_rst", 32'(pll_rst), 32'd0);
    check("tie_retries", 32'(retries), 32'd2);
    tick_n(7);
    check("tie_sys_rst_hold", 32'(sys_rst), 32'd1);
    tick();
    check("tie_sys_rst_rel", 32'(sys_rst), 32'd0);
    check("tie_ready", 32'(ready), 32'd1);
    $display("timeout/lock tie: released, retries=%0d", retries);

    // Loss in RUN; lock back high while in RESET_PLL (ignored there)
    lose_lock(3);
    pll_locked = 1'b1;
    tick();
    check("relock_lock_lost_clr", 32'(lock_lost), 32'd0);
    tick_n(2);
    check("relock_pll_rst_held", 32'(pll_rst), 32'd1);
    tick();
    check("relock_pll_rst_rel", 32'(pll_rst), 32'd0);
    tick_n(8);
    check("relock_sys_rst_hold", 32'(sys_rst), 32'd1);
    tick();
    check("relock_sys_rst_rel", 32'(sys_rst), 32'd0);
    check("relock_retries", 32'(retries), 32'd3);
    $display("relock with early lock: released, retries=%0d", retries);

    // Mid-operation reset from RUN
    rst = 1'b1;
    tick();
    check("mid_rst_sys_rst", 32'(sys_rst), 32'd1);
    check("mid_rst_pll_rst", 32'(pll_rst), 32'd1);
    check("mid_rst_retries", 32'(retries), 32'd0);
    check("mid_rst_ready", 32'(ready), 32'd0);
    rst = 1'b0;
    pll_locked = 1'b0;
    tick_n(3);
    check("mid_restart_pll_rst_held", 32'(pll_rst), 32'd1);
    tick();
    check("mid_restart_pll_rst_rel", 32'(pll_rst), 32'd0);
    $display("mid-operation reset: restarted, retries=%0d", retries);

    // Glitch in STABLE: lock rises, 5 stable cycles, drops for 3 edges, returns
    tick_n(10);
    for (int k = 0; k < 20; k++) begin
      pll_locked = !(k >= 6 && k <= 8);
      tick();
      check("glitch_sys_rst", 32'(sys_rst), (k < 19) ? 32'd1 : 32'd0);
      check("glitch_lock_lost", 32'(lock_lost), 32'd0);
    end
    check("glitch_retries", 32'(retries), 32'd0);
    $display("stable glitch: released after fresh stable window");

    // Loss then clean lock 10 cycles into WAIT_LOCK
    lose_lock(1);
    tick_n(4);
    check("clean_pll_rst_rel", 32'(pll_rst), 32'd0);
    tick_n(10);
    pll_locked = 1'b1;
    tick_n(10);
    check("clean_sys_rst_hold", 32'(sys_rst), 32'd1);
    tick();
    check("clean_sys_rst_rel", 32'(sys_rst), 32'd0);
    check("clean_ready", 32'(ready), 32'd1);
    check("clean_retries", 32'(retries), 32'd1);
    $display("clean lock: released, retries=%0d", retries);

    // Saturation: one loss then 300 timeouts
    lose_lock(2);
    tick_n(300 * 54);
    check("sat_retries", 32'(retries), 32'd255);
    check("sat_lock_lost", 32'(lock_lost), 32'd0);
    check("sat_sys_rst", 32'(sys_rst), 32'd1);
    $display("saturation: retries=%0d", retries);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
